countdown_timer: RTL and testbench
==================================

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 The block SHALL have one parameter: DIV, default 50000, meaning clk cycles per decrement tick (1 kHz at 50 MHz); the legal range is 2..65535.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port clear_, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port load, input, 1 bit: a one-cycle pulse that copies the preset digits into the count.
REQ-005 The block SHALL have port start_stop, input, 1 bit: a one-cycle pulse that starts, pauses, resumes or acknowledges.
REQ-006 The block SHALL have port preset_s, input, 4 bits: the seconds preset digit (BCD).
REQ-007 The block SHALL have port preset_ds, input, 4 bits: the tenths preset digit (BCD).
REQ-008 The block SHALL have port preset_cs, input, 4 bits: the hundredths preset digit (BCD).
REQ-009 The block SHALL have port preset_ms, input, 4 bits: the thousandths preset digit (BCD).
REQ-010 The block SHALL have outputs count_s, count_ds, count_cs and count_ms, each 4 bits, holding the current BCD digits for direct seven-segment drive.
REQ-011 The block SHALL have output running, 1 bit, which is high exactly when the state is RUN.
REQ-012 The block SHALL have output done, 1 bit, which is high exactly when the state is DONE.

Function
REQ-013 The block SHALL implement the states IDLE, RUN, PAUSE and DONE in a registered FSM.
REQ-014 The 4-digit count SHALL range 0000..9999; each digit SHALL always hold a value of 0..9.
REQ-015 On load, any preset digit greater than 9 SHALL be clamped to 9.
REQ-016 A load pulse in any state SHALL copy the clamped presets into the count, clear the prescaler and go to IDLE on the next edge.
REQ-017 When load and start_stop are both asserted in the same cycle, load SHALL win and start_stop SHALL be ignored.
REQ-018 In IDLE, start_stop with a nonzero count SHALL go to RUN; start_stop with count 0000 SHALL be ignored and the FSM SHALL stay in IDLE.
REQ-019 The prescaler SHALL be a counter of 0..DIV-1 that advances only in RUN and holds its value in IDLE, PAUSE and DONE.
REQ-020 In RUN, when the prescaler equals DIV-1, the prescaler SHALL wrap to 0 and the count SHALL decrement by 1 on that edge (a tick).
REQ-021 The first tick after a start from IDLE following a load SHALL occur DIV edges after the edge that entered RUN.
REQ-022 The decrement SHALL borrow per digit: a digit at 0 that must decrement SHALL become 9 and borrow from the next higher digit (for example, 1000 becomes 0999).
REQ-023 A tick that makes the count 0000 SHALL move the FSM to DONE on the same edge; RUN SHALL never hold a count of 0000.
REQ-024 In RUN, start_stop SHALL go to PAUSE; if a tick occurs in the same cycle, the decrement SHALL still apply.
REQ-025 If that same-cycle tick reaches 0000, DONE SHALL take precedence over PAUSE.
REQ-026 In PAUSE, start_stop SHALL go to RUN with the prescaler phase preserved, so the next tick occurs DIV-p edges later, where p is the held prescaler value.
REQ-027 In DONE, the count SHALL hold at 0000, and start_stop SHALL return the FSM to IDLE, acknowledging done.
REQ-028 All outputs SHALL be registered or decoded from the state register only, with no combinational path from inputs to outputs.

Reset
REQ-029 When clear_ is low, the block SHALL immediately and asynchronously set the state to IDLE, all count digits to 0, the prescaler to 0, running to 0 and done to 0.
REQ-030 While clear_ is low, load and start_stop SHALL be ignored.
REQ-031 The block SHALL resume normal operation on the first rising clk edge after clear_ goes high.
REQ-032 Asserting clear_ during RUN or PAUSE SHALL abort the countdown with no further ticks.

Verification (DIV=4)
REQ-033 The bench SHALL drive clear_ low at an arbitrary time -> outputs SHALL read 0000 with running=0 and done=0 without waiting for a clk edge.
REQ-034 The bench SHALL load preset 0,0,0,3 and pulse start_stop -> the count SHALL read 0002, 0001, 0000 at 4, 8 and 12 edges after RUN entry, with done=1 and running=0 at the 12th edge.
REQ-035 The bench SHALL load preset 1,0,0,0 and start -> after the first tick the count SHALL read 0,9,9,9; after the second tick it SHALL read 0,9,9,8.
REQ-036 The bench SHALL load 0,0,0,5, start, and pulse start_stop 2 edges after RUN entry, wait 10 cycles, then resume -> the count SHALL hold at 0005 during PAUSE, and the first tick SHALL occur 2 edges after resume.
REQ-037 The bench SHALL load with all preset digits at 4'hF, then pulse start_stop with load in the same cycle -> the count SHALL read 9999 and the FSM SHALL stay in IDLE; after a load of 0000, a start_stop pulse SHALL leave the FSM in IDLE.
REQ-038 The bench SHALL assert clear_ mid-RUN at count 0042 -> the count SHALL read 0000 in IDLE immediately, and no further ticks SHALL occur after release.

Source files
------------

// File: rtl/countdown_timer.sv
// ---------------------------------------------------------------------------
// countdown_timer
//
// Four-digit BCD countdown timer (s.ds cs ms, 0000..9999) driven by a
// prescaler that produces one decrement tick every DIV clock cycles.  A small
// FSM (IDLE / RUN / PAUSE / DONE) is controlled by two single-cycle pulses:
// load copies the preset digits into the count, and start_stop starts,
// pauses, resumes, or acknowledges a finished countdown.
//
// Parameters:
//   DIV         clk cycles per decrement tick (legal range 2..65535)
//
// Ports:
//   clk         rising-edge clock for all state
//   clear_      asynchronous active-low reset
//   load        pulse: load clamped preset digits, clear prescaler, go IDLE
//   start_stop  pulse: start / pause / resume / acknowledge done
//   preset_s    seconds preset digit (BCD, values above 9 clamp to 9)
//   preset_ds   tenths preset digit
//   preset_cs   hundredths preset digit
//   preset_ms   thousandths preset digit
//   count_s     current seconds digit
//   count_ds    current tenths digit
//   count_cs    current hundredths digit
//   count_ms    current thousandths digit
//   running     high while the countdown is running
//   done        high once the count has reached 0000, until acknowledged
// ---------------------------------------------------------------------------
module countdown_timer #(
    parameter int DIV = 50000
) (
    input  logic       clk,
    input  logic       clear_,
    input  logic       load,
    input  logic       start_stop,
    input  logic [3:0] preset_s,
    input  logic [3:0] preset_ds,
    input  logic [3:0] preset_cs,
    input  logic [3:0] preset_ms,
    output logic [3:0] count_s,
    output logic [3:0] count_ds,
    output logic [3:0] count_cs,
    output logic [3:0] count_ms,
    output logic       running,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE,
        DONE
    } state_t;

    localparam logic [15:0] PRESCALE_MAX = 16'(DIV - 1);

    state_t      state;
    logic [15:0] prescaler;

    logic        tick;
    logic        borrow_cs;
    logic        borrow_ds;
    logic        borrow_s;
    logic [3:0]  dec_s;
    logic [3:0]  dec_ds;
    logic [3:0]  dec_cs;
    logic [3:0]  dec_ms;
    logic        dec_zero;
    logic        count_zero;

    // Presets wider than a decimal digit are forced to 9 so the count
    // always stays valid BCD.
    function automatic logic [3:0] clamp_digit(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    // Tick detection and the count-minus-one value.  The decrement ripples a
    // borrow upward: a zero digit that must give up one becomes 9 and passes
    // the borrow on.  RUN never holds 0000, so the top digit never underflows
    // while the result is actually used.
    always_comb begin
        tick       = (state == RUN) && (prescaler == PRESCALE_MAX);

        dec_ms     = (count_ms == 4'd0) ? 4'd9 : count_ms - 4'd1;
        borrow_cs  = (count_ms == 4'd0);

        dec_cs     = count_cs;
        borrow_ds  = 1'b0;
        if (borrow_cs) begin
            dec_cs    = (count_cs == 4'd0) ? 4'd9 : count_cs - 4'd1;
            borrow_ds = (count_cs == 4'd0);
        end

        dec_ds     = count_ds;
        borrow_s   = 1'b0;
        if (borrow_ds) begin
            dec_ds   = (count_ds == 4'd0) ? 4'd9 : count_ds - 4'd1;
            borrow_s = (count_ds == 4'd0);
        end

        dec_s      = count_s;
        if (borrow_s) begin
            dec_s = count_s - 4'd1;
        end

        dec_zero   = (dec_s == 4'd0) && (dec_ds == 4'd0) &&
                     (dec_cs == 4'd0) && (dec_ms == 4'd0);
        count_zero = (count_s == 4'd0) && (count_ds == 4'd0) &&
                     (count_cs == 4'd0) && (count_ms == 4'd0);
    end

    // Main FSM with registered running/done flags.  load overrides every
    // other action, including a simultaneous start_stop.  The prescaler only
    // advances in RUN, so pausing preserves the tick phase.  A tick that
    // reaches zero goes to DONE even if start_stop asked for PAUSE on the
    // same edge.
    always_ff @(posedge clk or negedge clear_) begin
        if (!clear_) begin
            state     <= IDLE;
            prescaler <= 16'd0;
            count_s   <= 4'd0;
            count_ds  <= 4'd0;
            count_cs  <= 4'd0;
            count_ms  <= 4'd0;
            running   <= 1'b0;
            done      <= 1'b0;
        end else if (load) begin
            state     <= IDLE;
            prescaler <= 16'd0;
            count_s   <= clamp_digit(preset_s);
            count_ds  <= clamp_digit(preset_ds);
            count_cs  <= clamp_digit(preset_cs);
            count_ms  <= clamp_digit(preset_ms);
            running   <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_stop && !count_zero) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                RUN: begin
                    if (tick) begin
                        prescaler <= 16'd0;
                        count_s   <= dec_s;
                        count_ds  <= dec_ds;
                        count_cs  <= dec_cs;
                        count_ms  <= dec_ms;
                    end else begin
                        prescaler <= prescaler + 16'd1;
                    end

                    if (tick && dec_zero) begin
                        state   <= DONE;
                        running <= 1'b0;
                        done    <= 1'b1;
                    end else if (start_stop) begin
                        state   <= PAUSE;
                        running <= 1'b0;
                    end
                end
                PAUSE: begin
                    if (start_stop) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                DONE: begin
                    if (start_stop) begin
                        state <= IDLE;
                        done  <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_countdown_timer.sv
// ---------------------------------------------------------------------------
// tb_countdown_timer
//
// Self-checking bench for countdown_timer with DIV=4.  A reference model
// tracks the loaded value and the number of edges spent running; the
// displayed count is simply loaded - elapsed/DIV.  Directed sequences cover
// asynchronous clear, basic countdown, borrow, pause/resume phase, clamping
// and load priority, and abort by clear; a randomized phase follows.
// ---------------------------------------------------------------------------
module tb_countdown_timer;

    localparam int DIV = 4;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic       clk;
    logic       clear_;
    logic       load;
    logic       start_stop;
    logic [3:0] preset_s;
    logic [3:0] preset_ds;
    logic [3:0] preset_cs;
    logic [3:0] preset_ms;
    logic [3:0] count_s;
    logic [3:0] count_ds;
    logic [3:0] count_cs;
    logic [3:0] count_ms;
    logic       running;
    logic       done;

    int n_vectors;
    int n_miscompares;

    int m_loaded;
    int m_elapsed;
    int m_state;

    countdown_timer #(.DIV(DIV)) dut (
        .clk        (clk),
        .clear_     (clear_),
        .load       (load),
        .start_stop (start_stop),
        .preset_s   (preset_s),
        .preset_ds  (preset_ds),
        .preset_cs  (preset_cs),
        .preset_ms  (preset_ms),
        .count_s    (count_s),
        .count_ds   (count_ds),
        .count_cs   (count_cs),
        .count_ms   (count_ms),
        .running    (running),
        .done       (done)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        n_vectors++;
        if (observed !== expected) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)",
                     tag, observed, expected, $time);
        end
    endtask

    function automatic int clampDigit(input logic [3:0] d);
        return (d > 4'd9) ? 9 : int'(d);
    endfunction

    function automatic int modelRemaining();
        return m_loaded - (m_elapsed / DIV);
    endfunction

    function automatic logic [15:0] modelCountBcd();
        int c;
        logic [15:0] r;
        c = modelRemaining();
        r[15:12] = 4'((c / 1000) % 10);
        r[11:8]  = 4'((c / 100) % 10);
        r[7:4]   = 4'((c / 10) % 10);
        r[3:0]   = 4'(c % 10);
        return r;
    endfunction

    task automatic modelReset();
        m_loaded  = 0;
        m_elapsed = 0;
        m_state   = M_IDLE;
    endtask

    // Reference behaviour for one rising edge, given the inputs sampled there.
    task automatic modelStep(input logic l, input logic s, input logic [3:0] ps,
                             input logic [3:0] pds, input logic [3:0] pcs,
                             input logic [3:0] pms);
        if (!clear_) begin
            modelReset();
        end else if (l) begin
            m_loaded  = clampDigit(ps) * 1000 + clampDigit(pds) * 100 +
                        clampDigit(pcs) * 10 + clampDigit(pms);
            m_elapsed = 0;
            m_state   = M_IDLE;
        end else begin
            case (m_state)
                M_IDLE:  if (s && modelRemaining() != 0) m_state = M_RUN;
                M_RUN: begin
                    m_elapsed++;
                    if (modelRemaining() == 0) m_state = M_DONE;
                    else if (s)                m_state = M_PAUSE;
                end
                M_PAUSE: if (s) m_state = M_RUN;
                default: if (s) m_state = M_IDLE;
            endcase
        end
    endtask

    task automatic compareAll(input string tag);
        checkOutput({tag, "_cnt"}, {count_s, count_ds, count_cs, count_ms},
                    modelCountBcd());
        checkOutput({tag, "_run"}, {15'd0, running},
                    {15'd0, (m_state == M_RUN)});
        checkOutput({tag, "_done"}, {15'd0, done},
                    {15'd0, (m_state == M_DONE)});
    endtask

    // One clock cycle: drive inputs, let the edge happen, update the model,
    // drop the pulses and check on the falling edge.
    task automatic applyStimulus(input string tag, input logic l, input logic s,
                                 input logic [3:0] ps, input logic [3:0] pds,
                                 input logic [3:0] pcs, input logic [3:0] pms);
        load       = l;
        start_stop = s;
        preset_s   = ps;
        preset_ds  = pds;
        preset_cs  = pcs;
        preset_ms  = pms;
        @(posedge clk);
        modelStep(l, s, ps, pds, pcs, pms);
        #1;
        load       = 1'b0;
        start_stop = 1'b0;
        @(negedge clk);
        compareAll(tag);
    endtask

    task automatic idleCycles(input string tag, input int n);
        for (int i = 0; i < n; i++) applyStimulus(tag, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
    endtask

    // Pull clear_ low at an off-edge time and check the outputs right away.
    task automatic assertClear(input string tag);
        #($urandom_range(1, 3));
        clear_ = 1'b0;
        #1;
        modelReset();
        checkOutput({tag, "_async_cnt"}, {count_s, count_ds, count_cs, count_ms}, 16'h0000);
        checkOutput({tag, "_async_run"}, {15'd0, running}, 16'd0);
        checkOutput({tag, "_async_done"}, {15'd0, done}, 16'd0);
    endtask

    initial begin
        logic       l;
        logic       s;
        logic [3:0] ps;
        logic [3:0] pds;
        logic [3:0] pcs;
        logic [3:0] pms;

        n_vectors     = 0;
        n_miscompares = 0;
        clear_        = 1'b0;
        load          = 1'b0;
        start_stop    = 1'b0;
        preset_s      = 4'd0;
        preset_ds     = 4'd0;
        preset_cs     = 4'd0;
        preset_ms     = 4'd0;
        modelReset();

        // Reset state, with pulses ignored while clear_ is low.
        applyStimulus("rst_hold", 1'b1, 1'b1, 4'd5, 4'd5, 4'd5, 4'd5);
        applyStimulus("rst_hold", 1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0);
        clear_ = 1'b1;
        idleCycles("rst_rel", 1);

        // Basic countdown from 0003 to DONE.
        applyStimulus("b_load", 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 4'd3);
        applyStimulus("b_start", 1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0);
        for (int i = 1; i <= 12; i++) begin
            idleCycles("b_run", 1);
            if (i == 4)  checkOutput("b_edge4", {count_s, count_ds, count_cs, count_ms}, 16'h0002);
            if (i == 8)  checkOutput("b_edge8", {count_s, count_ds, count_cs, count_ms}, 16'h0001);
            if (i == 12) begin
                checkOutput("b_edge12", {count_s, count_ds, count_cs, count_ms}, 16'h0000);
                checkOutput("b_done", {15'd0, done}, 16'd1);
                checkOutput("b_running", {15'd0, running}, 16'd0);
            end
        end
        idleCycles("b_hold", 3);
        applyStimulus("b_ack", 1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0);
        checkOutput("b_ack_done", {15'd0, done}, 16'd0);

        // Borrow across digits: 1000 -> 0999 -> 0998.
        applyStimulus("br_load", 1'b1, 1'b0, 4'd1, 4'd0, 4'd0, 4'd0);
        applyStimulus("br_start", 1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0);
        idleCycles("br_run", DIV);
        checkOutput("br_tick1", {count_s, count_ds, count_cs, count_ms}, 16'h0999);
        idleCycles("br_run", DIV);
        checkOutput("br_tick2", {count_s, count_ds, count_cs, count_ms}, 16'h0998);

        // Pause two edges after RUN entry, hold, then resume with phase kept.
        applyStimulus("p_load", 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 4'd5);
        applyStimulus("p_start", 1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0);
        idleCycles("p_run", 1);
        applyStimulus("p_pause", 1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0);
        idleCycles("p_hold", 10);
        checkOutput("p_held", {count_s, count_ds, count_cs, count_ms}, 16'h0005);
        applyStimulus("p_resume", 1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0);
        idleCycles("p_run", 1);
        checkOutput("p_pre_tick", {count_s, count_ds, count_cs, count_ms}, 16'h0005);
        idleCycles("p_run", 1);
        checkOutput("p_tick", {count_s, count_ds, count_cs, count_ms}, 16'h0004);

        // Clamp and load-over-start_stop priority, then start ignored at 0000.
        applyStimulus("c_load", 1'b1, 1'b0, 4'hF, 4'hF, 4'hF, 4'hF);
        applyStimulus("c_both", 1'b1, 1'b1, 4'hF, 4'hF, 4'hF, 4'hF);
        checkOutput("c_clamp", {count_s, count_ds, count_cs, count_ms}, 16'h9999);
        checkOutput("c_idle", {15'd0, running}, 16'd0);
        idleCycles("c_idle", 2);
        applyStimulus("z_load", 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
        applyStimulus("z_start", 1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0);
        checkOutput("z_idle", {15'd0, running}, 16'd0);
        idleCycles("z_idle", 2);

        // Abort by clear mid-RUN at 0042.
        applyStimulus("a_load", 1'b1, 1'b0, 4'd0, 4'd0, 4'd4, 4'd3);
        applyStimulus("a_start", 1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0);
        idleCycles("a_run", DIV + 1);
        checkOutput("a_at42", {count_s, count_ds, count_cs, count_ms}, 16'h0042);
        assertClear("a");
        applyStimulus("a_held", 1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0);
        clear_ = 1'b1;
        idleCycles("a_after", 3 * DIV);
        checkOutput("a_no_tick", {count_s, count_ds, count_cs, count_ms}, 16'h0000);

        // Randomized phase against the model.
        for (int i = 0; i < 600; i++) begin
            l   = ($urandom_range(0, 11) == 0);
            s   = ($urandom_range(0, 4) == 0);
            ps  = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
            pds = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
            pcs = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
            pms = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 79) == 0) begin
                assertClear("r");
                applyStimulus("r_clr", l, s, ps, pds, pcs, pms);
                clear_ = 1'b1;
            end else begin
                applyStimulus("r", l, s, ps, pds, pcs, pms);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
